// File: rtl/branch_resolve.sv
// Branch resolution stage: detects mispredictions from the execute-stage
// comparator result, holds a corrected-PC redirect to fetch under valid/ready,
// squashes wrong-path beats for a fixed shadow window after each redirect,
// and publishes per-branch outcomes for predictor training.
module branch_resolve #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SHADOW_CYCLES = 2,
  parameter int unsigned STAT_WIDTH    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_is_jump,
  input  logic                  i_cmp_out,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_imm,
  input  logic                  i_pred_taken,
  output logic                  o_redirect_valid,
  output logic [DATA_WIDTH-1:0] o_redirect_pc,
  input  logic                  i_redirect_ready,
  output logic                  o_flush,
  output logic                  o_upd_valid,
  output logic                  o_upd_taken,
  output logic [DATA_WIDTH-1:0] o_upd_pc,
  output logic [STAT_WIDTH-1:0] o_mispredicts
);

  // Shadow counter must hold SHADOW_CYCLES; keep at least one bit when it is 0.
  localparam int unsigned CNT_W = (SHADOW_CYCLES > 0) ? $clog2(SHADOW_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_REDIRECT = 2'd1,
    S_SHADOW   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      shadow_q, shadow_d;
  logic [DATA_WIDTH-1:0] redirect_pc_d;
  logic                  upd_valid_d;
  logic                  upd_taken_d;
  logic [DATA_WIDTH-1:0] upd_pc_d;
  logic [STAT_WIDTH-1:0] mispredicts_d;

  logic                  taken;
  logic                  mispredict;
  logic [DATA_WIDTH-1:0] target;

  // Handshake and redirect status decoded straight from the state register.
  assign o_ready          = (state_q != S_REDIRECT);
  assign o_redirect_valid = (state_q == S_REDIRECT);
  assign o_flush          = o_redirect_valid && i_redirect_ready;

  // Resolve the presented beat: actual outcome, corrected target, mispredict flag.
  always_comb begin
    taken      = i_is_jump | i_cmp_out;
    target     = taken ? (i_pc + i_imm) : (i_pc + DATA_WIDTH'(4));
    mispredict = (taken != i_pred_taken);
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    redirect_pc_d = o_redirect_pc;
    upd_valid_d   = 1'b0;
    upd_taken_d   = o_upd_taken;
    upd_pc_d      = o_upd_pc;
    mispredicts_d = o_mispredicts;

    case (state_q)
      S_RUN: begin
        if (i_valid) begin
          upd_valid_d = 1'b1;
          upd_taken_d = taken;
          upd_pc_d    = i_pc;
          if (mispredict) begin
            if (o_mispredicts != {STAT_WIDTH{1'b1}}) begin
              mispredicts_d = o_mispredicts + STAT_WIDTH'(1);
            end
            redirect_pc_d = target;
            state_d       = S_REDIRECT;
          end
        end
      end

      S_REDIRECT: begin
        if (i_redirect_ready) begin
          if (SHADOW_CYCLES == 0) begin
            state_d = S_RUN;
          end else begin
            state_d  = S_SHADOW;
            shadow_d = CNT_W'(SHADOW_CYCLES);
          end
        end
      end

      S_SHADOW: begin
        // Incoming beats are consumed and dropped here.
        shadow_d = shadow_q - CNT_W'(1);
        if (shadow_q <= CNT_W'(1)) begin
          shadow_d = '0;
          state_d  = S_RUN;
        end
      end

      default: begin
        state_d  = S_RUN;
        shadow_d = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any pending redirect.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_RUN;
      shadow_q      <= '0;
      o_redirect_pc <= '0;
      o_upd_valid   <= 1'b0;
      o_upd_taken   <= 1'b0;
      o_upd_pc      <= '0;
      o_mispredicts <= '0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      o_redirect_pc <= redirect_pc_d;
      o_upd_valid   <= upd_valid_d;
      o_upd_taken   <= upd_taken_d;
      o_upd_pc      <= upd_pc_d;
      o_mispredicts <= mispredicts_d;
    end
  end

endmodule
